// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one FP multiplier between two requesters.
// Optional WAIT-state abort with quiet-NaN result when FP_TIMEOUT_EN is defined.
module fp_mul_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             ack0,
    output logic             done0,
    output logic [WIDTH-1:0] res0,
    output logic             err0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack1,
    output logic             done1,
    output logic [WIDTH-1:0] res1,
    output logic             err1,
    output logic [WIDTH-1:0] ABus,
    output logic [WIDTH-1:0] BBus,
    output logic             startFP,
    input  logic             doneFP,
    input  logic [WIDTH-1:0] resBus,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    localparam logic [WIDTH-1:0] QNAN = WIDTH'(32'h7FC0_0000);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t           state, state_n;
    logic             grant, grant_n;
    logic             last_grant, last_n;
    logic             pick, fin, fin_err;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] abus_n, bbus_n, res0_n, res1_n;
    logic             ack0_n, ack1_n, done0_n, done1_n, err0_n, err1_n, start_n, busy_n;

`ifdef FP_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt, cnt_n;
`endif

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last_grant;
        abus_n  = ABus;
        bbus_n  = BBus;
        res0_n  = res0;
        res1_n  = res1;
        err0_n  = err0;
        err1_n  = err1;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        done0_n = 1'b0;
        done1_n = 1'b0;
        start_n = 1'b0;
        pick    = 1'b0;
        fin     = 1'b0;
        fin_err = 1'b0;
        result  = resBus;
`ifdef FP_TIMEOUT_EN
        cnt_n   = cnt;
`endif
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that was not served last wins
                    pick    = (req0 && req1) ? ~last_grant : req1;
                    grant_n = pick;
                    abus_n  = pick ? a1 : a0;
                    bbus_n  = pick ? b1 : b0;
                    ack0_n  = ~pick;
                    ack1_n  = pick;
                    state_n = START;
                end
            end
            START: begin
                start_n = 1'b1;
                state_n = WAIT;
`ifdef FP_TIMEOUT_EN
                cnt_n   = '0;
`endif
            end
            WAIT: begin
                if (doneFP) begin
                    fin = 1'b1;
                end
`ifdef FP_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase

        if (fin) begin
            result = fin_err ? QNAN : resBus;
            if (grant) begin
                res1_n  = result;
                done1_n = 1'b1;
                err1_n  = fin_err;
            end else begin
                res0_n  = result;
                done0_n = 1'b1;
                err0_n  = fin_err;
            end
            last_n  = grant;
            state_n = IDLE;
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            ABus       <= '0;
            BBus       <= '0;
            res0       <= '0;
            res1       <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            startFP    <= 1'b0;
            busy       <= 1'b0;
`ifdef FP_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_n;
            ABus       <= abus_n;
            BBus       <= bbus_n;
            res0       <= res0_n;
            res1       <= res1_n;
            err0       <= err0_n;
            err1       <= err1_n;
            ack0       <= ack0_n;
            ack1       <= ack1_n;
            done0      <= done0_n;
            done1      <= done1_n;
            startFP    <= start_n;
            busy       <= busy_n;
`ifdef FP_TIMEOUT_EN
            cnt        <= cnt_n;
`endif
        end
    end

endmodule
